// File: rtl/alu_lockstep_monitor.sv
// ============================================================================
// Module   : alu_lockstep_monitor
// Purpose  : Registers dual-ALU lockstep results, counts samples/mismatches,
//            latches a fault after THRESH consecutive mismatches and checks
//            comparator x/y coherence. Optional first-mismatch snapshot is
//            built when ALU_LOCKSTEP_SNAPSHOT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lockstep_monitor #(
    parameter int THRESH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic [3:0]       alu_out1_i,
    input  logic [3:0]       alu_out2_i,
    input  logic             carry1_i,
    input  logic             carry2_i,
    input  logic [3:0]       x_i,
    input  logic             y_i,
    output logic             busy_o,
    output logic             fault_o,
    output logic             coh_err_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [9:0]       snap_o,
    output logic             snap_valid_o
);

    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_RUN   = 2'd1;
    localparam logic [1:0]       ST_FAULT = 2'd2;
    localparam logic [3:0]       THRESH_V = 4'(THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [3:0]       alu1_q, alu2_q, x_q;
    logic             c1_q, c2_q, y_q, s1_valid_q;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       consec_q, consec_d, consec_inc;
    logic             coh_err_q, coh_err_d;
    logic             w_clear, w_commit, w_mismatch, w_incoherent, w_trip;

    // Counters are only cleared by start_i while in IDLE or RUN; FAULT ignores it.
    assign w_clear      = start_i && (state_q == ST_IDLE || state_q == ST_RUN);
    assign w_commit     = s1_valid_q && (state_q == ST_RUN) && !start_i;
    assign w_mismatch   = (|x_q) | y_q;
    assign w_incoherent = (x_q != (alu1_q ^ alu2_q)) || (y_q != (c1_q ^ c2_q));
    assign consec_inc   = (consec_q == THRESH_V) ? THRESH_V : consec_q + 4'd1;
    assign w_trip       = w_commit && w_mismatch && (consec_inc == THRESH_V);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_i)     state_d = ST_RUN;
                else if (w_trip) state_d = ST_FAULT;
                else if (stop_i) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == ST_RUN);
        fault_o = (state_q == ST_FAULT);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            alu1_q     <= '0;
            alu2_q     <= '0;
            x_q        <= '0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            y_q        <= 1'b0;
            s1_valid_q <= 1'b0;
        end else begin
            alu1_q     <= alu_out1_i;
            alu2_q     <= alu_out2_i;
            x_q        <= x_i;
            c1_q       <= carry1_i;
            c2_q       <= carry2_i;
            y_q        <= y_i;
            s1_valid_q <= (state_q == ST_RUN) && !start_i;
        end
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        consec_d     = consec_q;
        coh_err_d    = coh_err_q;
        if (w_clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            consec_d     = '0;
            coh_err_d    = 1'b0;
        end else if (w_commit) begin
            if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_ONE;
            if (w_mismatch) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
                consec_d = consec_inc;
            end else begin
                consec_d = '0;
            end
            if (w_incoherent) coh_err_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            consec_q     <= '0;
            coh_err_q    <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            consec_q     <= consec_d;
            coh_err_q    <= coh_err_d;
        end
    end

    assign sample_cnt_o = sample_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign coh_err_o    = coh_err_q;

`ifdef ALU_LOCKSTEP_SNAPSHOT_EN
    logic [9:0] snap_q, snap_d;
    logic       snap_valid_q, snap_valid_d;

    // Only the first committed mismatch after a start is retained.
    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        if (w_clear) begin
            snap_d       = '0;
            snap_valid_d = 1'b0;
        end else if (w_commit && w_mismatch && !snap_valid_q) begin
            snap_d       = {alu1_q, alu2_q, c1_q, c2_q};
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_o       = snap_q;
    assign snap_valid_o = snap_valid_q;
`else
    assign snap_o       = '0;
    assign snap_valid_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/alu_lockstep_monitor.md
# alu_lockstep_monitor

Downstream consumer of the dual 4-bit ALU comparator stage. Registers both ALU results, the carry flags and the comparator's `x`/`y` difference outputs every clock, counts samples and lockstep mismatches, and latches a fault once a run of consecutive mismatches reaches a threshold. It also checks that the comparator's `x`/`y` outputs are coherent with the raw results. Status is exposed on flat ports for the wrapper to route to `io_out` or `la_data_out`.

## Interface
- `THRESH`, default 4: consecutive mismatching samples that trip the fault. Legal range is 1..15.
- `CNT_W`, default 16: width of the sample and error counters.

- `wb_clk_i`  in  1  single clock
- `wb_rst_ni`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  clear all counters and begin monitoring
- `stop_i`  in  1  end monitoring and return to IDLE
- `clear_i`  in  1  acknowledge a fault and go to IDLE
- `alu_out1_i`  in  4  ALU 1 result
- `alu_out2_i`  in  4  ALU 2 result
- `carry1_i`  in  1  ALU 1 carry out
- `carry2_i`  in  1  ALU 2 carry out
- `x_i`  in  4  comparator result difference
- `y_i`  in  1  comparator carry difference
- `busy_o`  out  1  state is RUN
- `fault_o`  out  1  state is FAULT
- `coh_err_o`  out  1  sticky flag: `x_i`/`y_i` disagree with the raw inputs
- `sample_cnt_o`  out  CNT_W  committed samples
- `err_cnt_o`  out  CNT_W  committed mismatching samples
- `snap_o`  out  10  first mismatch, packed as {alu_out1, alu_out2, carry1, carry2}
- `snap_valid_o`  out  1  `snap_o` holds a captured sample

## Operation
- **States:** IDLE, RUN, FAULT. Reset places the block in IDLE.
- **IDLE:**
  - `start_i` → RUN.
  - On the same edge: clear `sample_cnt_o`, `err_cnt_o`, the consecutive-mismatch counter, `coh_err_o`, `snap_valid_o` and `snap_o`.
  - `stop_i` and `clear_i` have no effect.
- **RUN:**
  - `start_i` restarts: same clears as from IDLE, stay in RUN. `start_i` has priority over `stop_i`.
  - `stop_i` → IDLE. Counters hold their values.
- **FAULT:**
  - `clear_i` → IDLE. Counters and snapshot hold their values.
  - `start_i` and `stop_i` are ignored.
- **Stage 1 (capture):**
  - Every edge, register all inputs.
  - `s1_valid` ← (state == RUN) and not `start_i`.
- **Stage 2 (commit):** executes on an edge when `s1_valid` is set, state is RUN and `start_i` is low.
  - mismatch = (|x) | y, using the registered values.
  - `sample_cnt_o` += 1.
  - If mismatch: `err_cnt_o` += 1 and the consecutive counter += 1. Otherwise the consecutive counter is set to 0.
  - Both CNT_W counters saturate at all-ones and do not wrap. The consecutive counter saturates at THRESH.
  - Coherence: if x ≠ (alu1 ^ alu2) or y ≠ (c1 ^ c2), set `coh_err_o`. It stays set until the next start.
  - If the consecutive count after increment equals THRESH, go to FAULT on the same edge.
- A capture made in the last RUN cycle before `stop_i` or a fault is discarded and never committed.

## Timing
- Latency: inputs present before edge k are committed at edge k+1. Counters, `fault_o` and `coh_err_o` are visible after edge k+1.
- `busy_o` and `fault_o` are decoded from registered state. There is no combinational path from any input to any output.
- **Reset values:** every output is 0; state is IDLE; `s1_valid` is 0.
- Reset asserted mid-RUN clears everything immediately and asynchronously. Release is synchronous to `wb_clk_i`.
- Window rule: `start_i` at edge E0 followed by `stop_i` at edge En gives n−1 committed samples.
- All control inputs are level-sampled each edge; single-cycle pulses are sufficient.

## Configuration
- Macro `ALU_LOCKSTEP_SNAPSHOT_EN`.
- **Defined:** on the first committed mismatch after a start, `snap_o` captures the registered {alu1, alu2, c1, c2} and `snap_valid_o` is set. Later mismatches do not overwrite it.
- **Undefined:** snapshot registers are not built; `snap_o` is tied to 0 and `snap_valid_o` is tied to 0.

## Test plan
- **Reset:** hold `wb_rst_ni`=0 with random inputs → all outputs 0. Assert reset mid-RUN → counters read 0 within the same cycle.
- **Clean window:** `start_i` at E0; alu1=alu2=4'h9, c1=c2=0, x=0, y=0; `stop_i` at E11 → `sample_cnt_o`=10, `err_cnt_o`=0, `busy_o`=0, `fault_o`=0.
- **Fault trip (THRESH=4):** mismatch pattern M,M,ok,M,M,M,M with alu1=4'h3, alu2=4'h7, x=4'h4 on mismatching samples → `err_cnt_o`=6, `fault_o` rises on the commit of the 7th sample. Afterwards `stop_i` is ignored and `clear_i` returns to IDLE.
- **Snapshot (macro defined):** first mismatch is alu1=4'hA, alu2=4'h2, c1=1, c2=0 → `snap_o`=10'b1010_0010_10 and `snap_valid_o`=1, unchanged by later mismatches. With the macro undefined → `snap_o`=0.
- **Coherence:** alu1=alu2=4'h5, x=4'h1 → `coh_err_o`=1 and `err_cnt_o` increments. `coh_err_o` stays 1 through `stop_i` and clears on the next `start_i`.
- **Saturation and priority:** with CNT_W=4, run 20 clean samples → `sample_cnt_o`=4'hF. Assert `start_i` and `stop_i` together in RUN → counters clear and state stays RUN.
